// File: rtl/instr_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : instr_load_arbiter
// Purpose  : Owns the single port of the instruction BRAM. After reset it takes
//            a length-prefixed program image from the loader stream and writes
//            it from address 0. It then releases the core and serves
//            fetch reads.
// Options  : CHECKSUM_EN - when defined, one trailing checksum word is
//            consumed after the image and compared against the running
//            wrap-around sum of the data words.
// Revision : 1.0 - initial release
// ============================================================================
module instr_load_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              core_hold,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              load_err
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] DEPTH_N = DATA_W'(DEPTH);

    localparam logic [1:0] ST_LEN  = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
`ifdef CHECKSUM_EN
    localparam logic [1:0] ST_CSUM = 2'd2;
`endif
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic [1:0]        state_q, state_d;
    // wcount has one extra bit so it can reach DEPTH without wrapping.
    // Its top bit set means the BRAM is full and further writes are suppressed.
    logic [ADDR_W:0]   wcount_q, wcount_d;
    // remaining counts every word still owed by the loader, including the
    // excess words of an oversize image, which are popped and dropped.
    logic [DATA_W-1:0] remaining_q, remaining_d;
    logic              load_err_q, load_err_d;
    logic              core_hold_q, core_hold_d;
    logic              fetch_valid_q, fetch_valid_d;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    // State register: all sequential state, asynchronously cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_LEN;
            wcount_q      <= '0;
            remaining_q   <= '0;
            load_err_q    <= 1'b0;
            core_hold_q   <= 1'b1;
            fetch_valid_q <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wcount_q      <= wcount_d;
            remaining_q   <= remaining_d;
            load_err_q    <= load_err_d;
            core_hold_q   <= core_hold_d;
            fetch_valid_q <= fetch_valid_d;
`ifdef CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    // Next-state and load bookkeeping.
    always_comb begin
        state_d     = state_q;
        wcount_d    = wcount_q;
        remaining_d = remaining_q;
        load_err_d  = load_err_q;
`ifdef CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_LEN: begin
                if (ld_valid) begin
                    wcount_d = '0;
`ifdef CHECKSUM_EN
                    sum_d    = '0;
`endif
                    if (ld_data == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        remaining_d = ld_data;
                        state_d     = ST_LOAD;
                        if (ld_data > DEPTH_N) begin
                            load_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    if (!wcount_q[ADDR_W]) begin
                        wcount_d = wcount_q + (ADDR_W+1)'(1);
                    end
                    remaining_d = remaining_q - DATA_W'(1);
`ifdef CHECKSUM_EN
                    sum_d       = sum_q + ld_data;
`endif
                    if (remaining_q == DATA_W'(1)) begin
`ifdef CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
            end
`ifdef CHECKSUM_EN
            ST_CSUM: begin
                if (ld_valid) begin
                    if (ld_data != sum_q) begin
                        load_err_d = 1'b1;
                    end
                    state_d = ST_RUN;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Registered side outputs: the hold drops on the first RUN cycle, and a
    // fetch is answered one cycle after it is accepted.
    always_comb begin
        core_hold_d   = (state_d != ST_RUN);
        fetch_valid_d = (state_q == ST_RUN) && fetch_req;
    end

    // BRAM port mux and handshake outputs. Writes occur only while loading
    // and reads only in RUN, so the two never contend for the port.
    always_comb begin
        ld_ready   = ld_valid && (state_q != ST_RUN);
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        if ((state_q == ST_LOAD) && ld_valid && !wcount_q[ADDR_W]) begin
            bram_we    = 1'b1;
            bram_addr  = wcount_q[ADDR_W-1:0];
            bram_wdata = ld_data;
        end else if ((state_q == ST_RUN) && fetch_req) begin
            bram_addr  = fetch_addr;
        end
        fetch_valid = fetch_valid_q;
        fetch_instr = fetch_valid_q ? bram_rdata : '0;
        core_hold   = core_hold_q;
        load_err    = load_err_q;
    end

endmodule
`default_nettype wire
